// File: rtl/dispatch_pkg.sv
// Shared types and reduction helpers for the thread dispatch lane filter.
// Helpers work on MAX_LANES-wide vectors; callers zero-extend and mask unused lanes.
package dispatch_pkg;

  localparam int MAX_LANES = 16;
  localparam int MAX_KEY_W = 32;
  localparam int MAX_TID_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TID_W-1:0] tid;
  } lane_slot_t;

  function automatic logic [4:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Pairwise tree: each level folds lane i+stride into lane i; masked lanes never win.
  function automatic logic [MAX_KEY_W-1:0] min_key_reduce(
    input logic [MAX_LANES-1:0][MAX_KEY_W-1:0] keys,
    input logic [MAX_LANES-1:0]                mask
  );
    logic [MAX_LANES-1:0][MAX_KEY_W-1:0] k;
    logic [MAX_LANES-1:0]                v;
    k = keys;
    v = mask;
    for (int lvl = 1; lvl < MAX_LANES; lvl = lvl * 2) begin
      for (int i = 0; i + lvl < MAX_LANES; i = i + 2 * lvl) begin
        if (v[i+lvl] && (!v[i] || (k[i+lvl] < k[i]))) k[i] = k[i+lvl];
        v[i] = v[i] | v[i+lvl];
      end
    end
    return k[0];
  endfunction

  // Returns {valid, tid} with the valid bit placed directly above a tid_w-bit tid.
  function automatic logic [MAX_TID_W:0] pack_slot(
    input logic                 valid,
    input logic [MAX_TID_W-1:0] tid,
    input int                   tid_w
  );
    lane_slot_t s;
    s.valid = valid;
    s.tid   = valid ? tid : '0;
    return (MAX_TID_W+1)'(s.tid) | ((MAX_TID_W+1)'(s.valid) << tid_w);
  endfunction

endpackage

// File: rtl/group_fifo.sv
// First-word-fall-through FIFO holding one lockstep lane group per entry.
// Output data is forced to zero while empty so consumers never see stale groups.
module group_fifo #(
  parameter int DATA_WIDTH = 44,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  assign full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign empty     = (r_count == '0);
  assign occupancy = r_count;
  assign w_doPop   = pop & ~empty & ~flush;
  assign w_doPush  = push & (~full | w_doPop) & ~flush;
  assign dout      = empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (rst_n && w_doPush) r_mem[r_wrPtr] <= din;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
      else if (w_doPop && !w_doPush) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/thread_dispatch_filter.sv
// Lane filter: picks the minimum-key active lanes, queues them as one group
// and issues groups over valid/ready; also tracks mode, errors and dispatched threads.
module thread_dispatch_filter
  import dispatch_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int TID_W      = 10,
  parameter int KEY_W      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int MODE_W     = ($clog2($clog2(NUM_LANES) + 1) < 1) ? 1 : $clog2($clog2(NUM_LANES) + 1),
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [MODE_W-1:0]                  unroll_log2,
  input  logic [NUM_LANES*(KEY_W+TID_W)-1:0] next_tid,
  input  logic [NUM_LANES-1:0]               lane_valid,
  output logic [NUM_LANES-1:0]               update,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_LANES-1:0]               out_lane_valid,
  output logic [NUM_LANES*TID_W-1:0]         out_tid,
  output logic [CNT_W-1:0]                   occupancy,
  output logic                               fifo_full,
  output logic                               fifo_empty,
  output logic                               mode_busy,
  output logic                               err_illegal_mode,
  output logic [31:0]                        thread_count
);

  localparam int LOG2_LANES = $clog2(NUM_LANES);
  localparam int LANE_W     = KEY_W + TID_W;
  localparam int DATA_W     = NUM_LANES * (TID_W + 1);

  logic [MODE_W-1:0]                   r_activeMode;
  logic                                r_errIllegal;
  logic [31:0]                         r_threadCount;
  logic [MAX_LANES-1:0][MAX_KEY_W-1:0] w_keys;
  logic [MAX_LANES-1:0]                w_cand;
  logic [MAX_KEY_W-1:0]                w_minKey;
  logic [NUM_LANES-1:0]                w_sel;
  logic [DATA_W-1:0]                   w_entry;
  logic [DATA_W-1:0]                   w_head;
  logic                                w_illegal;
  logic                                w_modeBusy;
  logic                                w_push;
  logic                                w_pop;
  logic                                w_full;
  logic                                w_empty;

  // Lanes outside the active range are masked here, so they can never be selected.
  always_comb begin
    w_keys = '0;
    w_cand = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_keys[i] = MAX_KEY_W'(next_tid[i*LANE_W+TID_W +: KEY_W]);
      w_cand[i] = lane_valid[i] & ((32'(i) >> r_activeMode) == 32'd0);
    end
  end

  assign w_minKey = min_key_reduce(w_keys, w_cand);

  always_comb begin
    w_sel   = '0;
    w_entry = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_sel[i] = w_cand[i] & (w_keys[i] == w_minKey);
      w_entry[i*(TID_W+1) +: TID_W+1] =
        (TID_W+1)'(pack_slot(w_sel[i], MAX_TID_W'(next_tid[i*LANE_W +: TID_W]), TID_W));
    end
  end

  assign w_illegal  = 32'(unroll_log2) > 32'(LOG2_LANES);
  assign w_modeBusy = (unroll_log2 != r_activeMode);
  assign w_pop      = rst_n & ~w_empty & out_ready & ~flush;
  assign w_push     = rst_n & (|w_sel) & ~w_modeBusy & ~w_illegal & ~flush & (~w_full | w_pop);
  assign update     = w_push ? w_sel : '0;

  group_fifo #(
    .DATA_WIDTH (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_group_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .flush     (flush),
    .din       (w_entry),
    .dout      (w_head),
    .occupancy (occupancy),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    out_lane_valid = '0;
    out_tid        = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      out_lane_valid[i]          = w_head[i*(TID_W+1) + TID_W];
      out_tid[i*TID_W +: TID_W]  = w_head[i*(TID_W+1) +: TID_W];
    end
  end

  // Mode only changes once the FIFO has drained, so stored groups keep their lane layout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_activeMode  <= '0;
      r_errIllegal  <= 1'b0;
      r_threadCount <= '0;
    end else begin
      if (w_illegal) r_errIllegal <= 1'b1;
      if (w_modeBusy && w_empty && !w_push && !w_illegal) r_activeMode <= unroll_log2;
      if (w_pop) r_threadCount <= r_threadCount + 32'(popcount(MAX_LANES'(out_lane_valid)));
    end
  end

  assign out_valid        = ~w_empty;
  assign fifo_full        = w_full;
  assign fifo_empty       = w_empty;
  assign mode_busy        = w_modeBusy;
  assign err_illegal_mode = r_errIllegal;
  assign thread_count     = r_threadCount;

endmodule

// File: tb/tb_thread_dispatch_filter.sv
// Randomised bench for thread_dispatch_filter: a queue-based model predicts each
// group, a negedge monitor compares the FIFO head against the expected queue.
module tb_thread_dispatch_filter;

  localparam int NL     = 4;
  localparam int TW     = 10;
  localparam int KW     = 10;
  localparam int DEPTH  = 4;
  localparam int MW     = 2;
  localparam int CW     = 3;
  localparam int LOG2NL = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [MW-1:0]       unroll_log2;
  logic [NL*(KW+TW)-1:0] next_tid;
  logic [NL-1:0]       lane_valid;
  logic [NL-1:0]       update;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [NL-1:0]       out_lane_valid;
  logic [NL*TW-1:0]    out_tid;
  logic [CW-1:0]       occupancy;
  logic                fifo_full;
  logic                fifo_empty;
  logic                mode_busy;
  logic                err_illegal_mode;
  logic [31:0]         thread_count;

  always #5 clk = ~clk;

  thread_dispatch_filter #(
    .NUM_LANES  (NL),
    .TID_W      (TW),
    .KEY_W      (KW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .unroll_log2      (unroll_log2),
    .next_tid         (next_tid),
    .lane_valid       (lane_valid),
    .update           (update),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_lane_valid   (out_lane_valid),
    .out_tid          (out_tid),
    .occupancy        (occupancy),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .mode_busy        (mode_busy),
    .err_illegal_mode (err_illegal_mode),
    .thread_count     (thread_count)
  );

  typedef struct packed {
    logic [NL-1:0]    lv;
    logic [NL*TW-1:0] tids;
  } group_t;

  group_t      expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          startSize = 0;
  int          modelMode = 0;
  bit          modelErr = 1'b0;
  logic [31:0] modelThreads = '0;
  int          keyA[NL];
  int          tidA[NL];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int countOnes(input logic [NL-1:0] v);
    int n = 0;
    for (int i = 0; i < NL; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic setLanes(input int k0, input int k1, input int k2, input int k3,
                          input int t0, input int t1, input int t2, input int t3);
    keyA[0] = k0; keyA[1] = k1; keyA[2] = k2; keyA[3] = k3;
    tidA[0] = t0; tidA[1] = t1; tidA[2] = t2; tidA[3] = t3;
  endtask

  // One clock cycle: check registered state, drive inputs, predict and check this cycle.
  task automatic applyStimulus(input logic [1:0] mode, input logic [NL-1:0] lv,
                               input bit ready, input bit fl, input bit rstIn);
    logic [NL-1:0] expSel;
    int            minK;
    bit            any, busy, illegal, push, pop, active;
    group_t        g;
    int            sizeNow;
    @(posedge clk);
    #1;
    checkOutput("occupancy", 64'(occupancy), 64'(expQ.size()));
    checkOutput("fifo_empty", 64'(fifo_empty), 64'(expQ.size() == 0));
    checkOutput("fifo_full", 64'(fifo_full), 64'(expQ.size() == DEPTH));
    checkOutput("err_illegal_mode", 64'(err_illegal_mode), 64'(modelErr));
    checkOutput("thread_count", 64'(thread_count), 64'(modelThreads));

    rst_n       = rstIn;
    unroll_log2 = mode;
    lane_valid  = lv;
    out_ready   = ready;
    flush       = fl;
    for (int i = 0; i < NL; i++) next_tid[i*(KW+TW) +: KW+TW] = {KW'(keyA[i]), TW'(tidA[i])};
    #1;
    sizeNow   = expQ.size();
    startSize = sizeNow;

    if (!rstIn) begin
      checkOutput("update_in_reset", 64'(update), 64'(0));
      expQ.delete();
      modelMode    = 0;
      modelErr     = 1'b0;
      modelThreads = '0;
      return;
    end

    busy    = (int'(mode) != modelMode);
    illegal = (int'(mode) > LOG2NL);
    any     = 1'b0;
    minK    = 0;
    for (int i = 0; i < NL; i++) begin
      active = lv[i] && (i < (1 << modelMode));
      if (active && (!any || keyA[i] < minK)) begin
        minK = keyA[i];
        any  = 1'b1;
      end
    end
    expSel = '0;
    for (int i = 0; i < NL; i++)
      if (lv[i] && (i < (1 << modelMode)) && keyA[i] == minK) expSel[i] = 1'b1;

    pop  = (sizeNow > 0) && ready && !fl;
    push = any && !busy && !illegal && !fl && (sizeNow < DEPTH || pop);
    checkOutput("update", 64'(update), 64'(push ? expSel : '0));
    checkOutput("mode_busy", 64'(mode_busy), 64'(busy));

    if (fl) expQ.delete();
    else begin
      if (pop) modelThreads += 32'(countOnes(expQ[0].lv));
      if (push) begin
        g.lv   = expSel;
        g.tids = '0;
        for (int i = 0; i < NL; i++) if (expSel[i]) g.tids[i*TW +: TW] = TW'(tidA[i]);
        expQ.push_back(g);
      end
    end
    if (illegal) modelErr = 1'b1;
    if (busy && sizeNow == 0 && !push && !illegal) modelMode = int'(mode);
  endtask

  // Head monitor: validates the presented group and retires it on a handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("out_valid", 64'(out_valid), 64'(startSize != 0));
      if (out_valid !== 1'b1)
        checkOutput("empty_outputs", 64'({out_lane_valid, out_tid}), 64'(0));
      else if (flush === 1'b0) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL head_group: got lane_valid %b, expected no group", out_lane_valid);
        end else begin
          checkOutput("head_lane_valid", 64'(out_lane_valid), 64'(expQ[0].lv));
          checkOutput("head_tid", 64'(out_tid), 64'(expQ[0].tids));
          if (out_ready === 1'b1) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    logic [1:0] curMode;
    rst_n = 1'b0; unroll_log2 = '0; next_tid = '0; lane_valid = '0;
    out_ready = 1'b0; flush = 1'b0;
    setLanes(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset and min-key tie selection");
    applyStimulus(2, 4'b0000, 0, 0, 0);
    applyStimulus(2, 4'b0000, 0, 0, 0);
    applyStimulus(2, 4'b0000, 0, 0, 1);
    setLanes(5, 3, 3, 9, 10, 11, 12, 13);
    applyStimulus(2, 4'b1111, 0, 0, 1);
    checkOutput("t1_update", 64'(update), 64'(4'b0110));
    applyStimulus(2, 4'b0000, 0, 0, 1);
    checkOutput("t1_head", 64'({out_lane_valid, out_tid}), 64'({4'b0110, 10'd0, 10'd12, 10'd11, 10'd0}));
    applyStimulus(2, 4'b0000, 1, 0, 1);

    $display("[TB] all-ones key in single-lane mode");
    applyStimulus(0, 4'b0000, 0, 0, 1);
    setLanes(10'h3FF, 0, 0, 0, 77, 78, 0, 0);
    applyStimulus(0, 4'b0011, 0, 0, 1);
    checkOutput("t2_update", 64'(update), 64'(4'b0001));
    applyStimulus(0, 4'b0000, 1, 0, 1);

    $display("[TB] full FIFO and push with pop");
    for (int n = 0; n < 4; n++) begin
      setLanes(n, 0, 0, 0, 100 + n, 0, 0, 0);
      applyStimulus(0, 4'b0001, 0, 0, 1);
    end
    applyStimulus(0, 4'b0001, 0, 0, 1);
    checkOutput("t3_full", 64'(fifo_full), 64'(1));
    checkOutput("t3_full_update", 64'(update), 64'(0));
    setLanes(1, 0, 0, 0, 200, 0, 0, 0);
    applyStimulus(0, 4'b0001, 1, 0, 1);
    checkOutput("t3_push_pop_update", 64'(update), 64'(4'b0001));

    $display("[TB] mode switch waits for drain");
    for (int n = 0; n < 5; n++) applyStimulus(0, 4'b0000, 1, 0, 1);
    applyStimulus(1, 4'b0000, 0, 0, 1);
    setLanes(4, 4, 0, 0, 300, 301, 0, 0);
    applyStimulus(1, 4'b0011, 0, 0, 1);
    applyStimulus(1, 4'b0011, 0, 0, 1);
    setLanes(1, 1, 1, 1, 400, 401, 402, 403);
    applyStimulus(2, 4'b1111, 0, 0, 1);
    checkOutput("t4_busy", 64'(mode_busy), 64'(1));
    applyStimulus(2, 4'b1111, 1, 0, 1);
    applyStimulus(2, 4'b1111, 1, 0, 1);
    applyStimulus(2, 4'b1111, 0, 0, 1);
    applyStimulus(2, 4'b0000, 0, 0, 1);
    checkOutput("t4_busy_cleared", 64'(mode_busy), 64'(0));

    $display("[TB] flush discards stored groups");
    for (int n = 0; n < 3; n++) begin
      setLanes(2, n, 2, 3, 500 + n, 510 + n, 520 + n, 530 + n);
      applyStimulus(2, 4'b1111, 0, 0, 1);
    end
    applyStimulus(2, 4'b1111, 1, 1, 1);
    checkOutput("t5_flush_update", 64'(update), 64'(0));
    applyStimulus(2, 4'b0000, 0, 0, 1);
    checkOutput("t5_occupancy", 64'(occupancy), 64'(0));

    $display("[TB] randomised traffic");
    curMode = 2'd2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) curMode = 2'($urandom_range(0, 2));
      for (int i = 0; i < NL; i++) begin
        keyA[i] = ($urandom_range(0, 9) == 0) ? 10'h3FF : int'($urandom_range(0, 3));
        tidA[i] = int'($urandom_range(0, 1023));
      end
      applyStimulus(curMode, 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 29) == 0, 1);
    end

    $display("[TB] illegal mode is sticky until reset");
    setLanes(1, 1, 1, 1, 1, 2, 3, 4);
    for (int n = 0; n < 6; n++) applyStimulus(0, 4'b0000, 1, 0, 1);
    for (int n = 0; n < 3; n++) applyStimulus(3, 4'b1111, 1, 0, 1);
    checkOutput("t6_err_set", 64'(err_illegal_mode), 64'(1));
    for (int n = 0; n < 3; n++) applyStimulus(0, 4'b1111, 1, 0, 1);
    checkOutput("t6_err_sticky", 64'(err_illegal_mode), 64'(1));
    applyStimulus(0, 4'b0000, 0, 0, 0);
    applyStimulus(0, 4'b0000, 0, 0, 1);
    checkOutput("t6_err_cleared", 64'(err_illegal_mode), 64'(0));
    checkOutput("t6_count_cleared", 64'(thread_count), 64'(0));
    applyStimulus(0, 4'b0000, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
